// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full adder plus a carry flop, operands shifted LSB-first.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             load, last;
  logic             fa_s, fa_co;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last = (state == SHIFT) && (cnt == LAST);

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      busy  <= (state_nx == SHIFT);
      done  <= (state_nx == DONE);
      if (load) begin
        a_sr  <= a;
        b_sr  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        carry  <= fa_co;
        sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
        // Hold the counter on the final bit so it never wraps within an operation.
        if (!last) cnt <= cnt + 1'b1;
      end
      // Result registers only move on SHIFT->DONE; the final bit bypasses sum_sr.
      if (last) begin
        sum  <= {fa_s, sum_sr[WIDTH-1:1]};
        cout <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
        ovf  <= carry ^ fa_co;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed vectors and an exhaustive WIDTH=4 stream.

module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

`ifdef SERIAL_ADDER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
  assign ovf8 = 1'b0;
  assign ovf4 = 1'b0;
`endif

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [9:0] q8[$];
  logic [5:0] q4[$];
  bit sp8 = 0, sp4 = 0;
  int last8 = -1, last4 = -1;
  int ndone8 = 0, ndone4 = 0;

  // {ovf,cout,sum} expected for the WIDTH=8 directed vectors
  localparam logic [7:0] VA [0:6] = '{8'h03, 8'hFF, 8'hFF, 8'hA5, 8'h7F, 8'h80, 8'h10};
  localparam logic [7:0] VB [0:6] = '{8'h05, 8'h01, 8'hFF, 8'h5A, 8'h01, 8'hFF, 8'h20};
  localparam logic       VC [0:6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [9:0] VE [0:6] = '{10'h008, 10'h100, 10'h1FF, 10'h100, 10'h280, 10'h37F, 10'h030};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a done pulse is presented.
  always @(negedge clk) begin
    logic [9:0] g8, e8;
    logic [5:0] g4, e4;
    if (done8) begin
      ndone8++;
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL u8_unexpected_done: got sum=0x%0h with nothing expected", sum8);
      end else begin
        e8 = q8.pop_front();
        g8 = {ovf8, cout8, sum8};
        if (!OVF_EN) begin g8[9] = 1'b0; e8[9] = 1'b0; end
        chk("u8_result", int'(g8), int'(e8));
      end
      if (sp8 && last8 >= 0) chk("u8_done_spacing", cyc - last8, 9);
      last8 = cyc;
    end
    if (done4) begin
      ndone4++;
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL u4_unexpected_done: got sum=0x%0h with nothing expected", sum4);
      end else begin
        e4 = q4.pop_front();
        g4 = {ovf4, cout4, sum4};
        if (!OVF_EN) begin g4[5] = 1'b0; e4[5] = 1'b0; end
        chk("u4_result", int'(g4), int'(e4));
      end
      if (sp4 && last4 >= 0) chk("u4_done_spacing", cyc - last4, 5);
      last4 = cyc;
    end
  end

  // Single WIDTH=8 operation; with hold, start stays high and operands churn during SHIFT.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                     input logic [9:0] texp, input bit hold);
    int busy_n, t;
    @(negedge clk);
    a8 = ta; b8 = tb_; cin8 = tc; start8 = 1'b1;
    q8.push_back(texp);
    @(negedge clk);
    if (!hold) start8 = 1'b0;
    busy_n = 0; t = 0;
    while (!done8 && t < 40) begin
      if (busy8) busy_n++;
      if (hold) begin a8 = 8'($urandom); b8 = 8'($urandom); cin8 = ~cin8; end
      @(negedge clk);
      t++;
    end
    start8 = 1'b0;
    if (t >= 40) begin
      checks++; errors++;
      $display("FAIL u8_timeout: no done within 40 cycles");
    end
    chk("u8_busy_cycles", busy_n, 8);
  endtask

  task automatic stream8();
    int t;
    sp8 = 1; last8 = -1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      a8 = VA[i]; b8 = VB[i]; cin8 = VC[i]; start8 = 1'b1;
      q8.push_back(VE[i]);
      t = 0;
      do begin @(negedge clk); t++; end while (!done8 && t < 40);
      if (t >= 40) begin
        checks++; errors++;
        $display("FAIL u8_stream_timeout: vector %0d", i);
      end
    end
    start8 = 1'b0;
    sp8 = 0;
  endtask

  task automatic stream4();
    int t;
    logic [4:0] s5;
    logic       ov;
    sp4 = 1; last4 = -1;
    @(negedge clk);
    for (int i = 0; i < 512; i++) begin
      a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8]; start4 = 1'b1;
      s5 = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
      ov = (a4[3] == b4[3]) && (s5[3] != a4[3]);
      q4.push_back({ov, s5});
      t = 0;
      do begin @(negedge clk); t++; end while (!done4 && t < 20);
      if (t >= 20) begin
        checks++; errors++;
        $display("FAIL u4_stream_timeout: vector %0d", i);
      end
    end
    start4 = 1'b0;
    sp4 = 0;
  endtask

  initial begin
    int n0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("u8_reset_state", int'({busy8, done8, cout8, sum8}), 0);
    chk("u4_reset_state", int'({busy4, done4, cout4, sum4}), 0);
    rst_n = 1'b1;

    op8(8'h03, 8'h05, 1'b0, 10'h008, 1'b0);
    op8(8'h12, 8'h34, 1'b0, 10'h046, 1'b1);
    repeat (12) @(negedge clk);
    stream8();
    repeat (3) @(negedge clk);

    // Abort mid-SHIFT: the previous sum (0x30) must be cleared and no done follow.
    a8 = 8'h21; b8 = 8'h43; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    q8.delete();
    @(negedge clk);
    chk("u8_abort_state", int'({busy8, done8, cout8, sum8}), 0);
    rst_n = 1'b1;
    n0 = ndone8;
    repeat (15) @(negedge clk);
    chk("u8_no_done_after_abort", ndone8 - n0, 0);

    stream4();
    repeat (8) @(negedge clk);
    chk("u8_queue_drained", q8.size(), 0);
    chk("u4_queue_drained", q4.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
